// File: rtl/minx_mem_responder.sv
// Memory responder for the minx CPU bus: on-chip BIOS ROM and RAM, a
// zero-reading register window, and a handshaked cartridge port with timeout.
`timescale 1ns/1ps

module minx_mem_responder #(
    parameter int CART_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    input  logic [1:0]  bus_status,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [7:0]  bus_data_out,
    output logic        stall,
    input  logic        bios_load_we,
    input  logic [11:0] bios_load_addr,
    input  logic [7:0]  bios_load_data,
    output logic        cart_req,
    output logic        cart_we,
    output logic [20:0] cart_addr,
    output logic [7:0]  cart_wdata,
    input  logic        cart_ack,
    input  logic [7:0]  cart_rdata
);

    typedef enum logic {
        ST_IDLE,
        ST_CART_WAIT
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(CART_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        stall_q, stall_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [20:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  tmo_q, tmo_d;

    logic [7:0]  bios_mem [4096];
    logic [7:0]  ram_mem  [4096];

    logic        start_rd, start_wr, accept;
    logic        in_bios, in_ram, in_reg, in_cart;
    logic        ram_we;
    logic [11:0] mem_idx;

    // Region decode looks only at the upper address bits; offsets use the low bits.
    always_comb begin
        mem_idx  = bus_address_in[11:0];
        start_rd = clk_ce && (bus_status == 2'd3) && bus_read;
        start_wr = clk_ce && (bus_status == 2'd2) && bus_write;
        in_bios  = (bus_address_in[23:12] == 12'h000);
        in_ram   = (bus_address_in[23:12] == 12'h001);
        in_reg   = (bus_address_in[23:8] == 16'h0020);
        in_cart  = !(in_bios || in_ram || in_reg);
        accept   = (state_q == ST_IDLE) && (start_rd || start_wr);
        ram_we   = accept && start_wr && in_ram;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        stall_d = stall_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;

        if (state_q == ST_IDLE) begin
            if (accept) begin
                if (in_bios && start_rd) begin
                    data_d = bios_mem[mem_idx];
                end else if (in_ram && start_rd) begin
                    data_d = ram_mem[mem_idx];
                end else if (in_reg) begin
                    data_d = 8'h00;
                end else if (in_cart) begin
                    state_d = ST_CART_WAIT;
                    req_d   = 1'b1;
                    stall_d = 1'b1;
                    addr_d  = bus_address_in[20:0];
                    we_d    = start_wr;
                    wdata_d = bus_data_in;
                    tmo_d   = 8'd0;
                end
            end
        end else begin
            // An ack arriving on the timeout cycle still wins and returns real data.
            if (cart_ack) begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                stall_d = 1'b0;
                if (!we_q) begin
                    data_d = cart_rdata;
                end
            end else if (tmo_q == TIMEOUT_LAST) begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                stall_d = 1'b0;
                tmo_d   = tmo_q + 8'd1;
                if (!we_q) begin
                    data_d = 8'hFF;
                end
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            stall_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 21'd0;
            wdata_q <= 8'h00;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            stall_q <= stall_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end

    // Memory arrays are deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (bios_load_we) begin
            bios_mem[bios_load_addr] <= bios_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[mem_idx] <= bus_data_in;
        end
    end

    assign bus_data_out = data_q;
    assign stall        = stall_q;
    assign cart_req     = req_q;
    assign cart_we      = we_q;
    assign cart_addr    = addr_q;
    assign cart_wdata   = wdata_q;

endmodule

// File: tb/tb_minx_mem_responder.sv
// Randomised bench for minx_mem_responder against a region/array model of the
// memory map and the cartridge handshake.
`timescale 1ns/1ps

module tb_minx_mem_responder;

    localparam int CART_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_ce = 1'b0;
    logic [23:0] bus_address_in = '0;
    logic [7:0]  bus_data_in = '0;
    logic [1:0]  bus_status = '0;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic [7:0]  bus_data_out;
    logic        stall;
    logic        bios_load_we = 1'b0;
    logic [11:0] bios_load_addr = '0;
    logic [7:0]  bios_load_data = '0;
    logic        cart_req;
    logic        cart_we;
    logic [20:0] cart_addr;
    logic [7:0]  cart_wdata;
    logic        cart_ack = 1'b0;
    logic [7:0]  cart_rdata = '0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  biosM [4096];
    logic [7:0]  ramM  [4096];
    logic [7:0]  expData = 8'h00;

    minx_mem_responder #(.CART_TIMEOUT(CART_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clk_ce(clk_ce),
        .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
        .bus_status(bus_status), .bus_read(bus_read), .bus_write(bus_write),
        .bus_data_out(bus_data_out), .stall(stall),
        .bios_load_we(bios_load_we), .bios_load_addr(bios_load_addr),
        .bios_load_data(bios_load_data),
        .cart_req(cart_req), .cart_we(cart_we), .cart_addr(cart_addr),
        .cart_wdata(cart_wdata), .cart_ack(cart_ack), .cart_rdata(cart_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleBus();
        clk_ce = 1'b0;
        bus_status = 2'd0;
        bus_read = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // 0 BIOS, 1 RAM, 2 registers, 3 cartridge
    function automatic int regionOf(input logic [23:0] a);
        if (a < 24'h001000) return 0;
        if (a < 24'h002000) return 1;
        if (a < 24'h002100) return 2;
        return 3;
    endfunction

    task automatic loadBios(input logic [11:0] a, input logic [7:0] d);
        bios_load_we = 1'b1;
        bios_load_addr = a;
        bios_load_data = d;
        tick();
        bios_load_we = 1'b0;
        biosM[a] = d;
    endtask

    // One bus cycle plus, for cartridge accesses, the full handshake.
    // ackDelay = number of cycles cart_req stays high before the ack; 0 = never ack.
    task automatic applyStimulus(input logic [1:0] status, input logic [23:0] addr,
                                 input logic [7:0] wdata, input logic ce,
                                 input int ackDelay, input logic [7:0] rdata);
        int          region;
        bit          accepted;
        bit          done;
        bit          acked;
        int          n;
        int          idx;
        logic [20:0] expAddr;
        region   = regionOf(addr);
        accepted = ce && (status == 2'd2 || status == 2'd3);
        idx      = int'(addr) % 4096;
        expAddr  = 21'(int'(addr) % (1 << 21));
        bus_status = status;
        bus_read = status[0];
        bus_write = (status == 2'd2);
        bus_address_in = addr;
        bus_data_in = wdata;
        clk_ce = ce;
        tick();
        idleBus();
        acked = 1'b0;
        if (accepted && region == 3) begin
            checkOutput("cart_req_start", 32'(cart_req), 32'd1);
            checkOutput("stall_start", 32'(stall), 32'd1);
            checkOutput("cart_addr", 32'(cart_addr), 32'(expAddr));
            checkOutput("cart_we", 32'(cart_we), 32'(status == 2'd2));
            checkOutput("cart_wdata", 32'(cart_wdata), 32'(wdata));
            done = 1'b0;
            n = 0;
            while (!done) begin
                n++;
                acked = (n == ackDelay);
                cart_ack = acked;
                cart_rdata = acked ? rdata : 8'($urandom);
                bus_status = 2'd2;
                bus_write = 1'b1;
                clk_ce = 1'b1;
                bus_address_in = 24'h001000 + 24'($urandom_range(0, 4095));
                bus_data_in = 8'($urandom);
                tick();
                cart_ack = 1'b0;
                idleBus();
                done = acked || (n >= CART_TIMEOUT);
                checkOutput("cart_req_wait", 32'(cart_req), 32'(!done));
                checkOutput("stall_wait", 32'(stall), 32'(!done));
                if (!done) begin
                    checkOutput("cart_addr_hold", 32'(cart_addr), 32'(expAddr));
                    checkOutput("cart_we_hold", 32'(cart_we), 32'(status == 2'd2));
                    checkOutput("cart_wdata_hold", 32'(cart_wdata), 32'(wdata));
                end
            end
            if (status == 2'd3) expData = acked ? rdata : 8'hFF;
        end else if (accepted) begin
            case (region)
                0: if (status == 2'd3) expData = biosM[idx];
                1: if (status == 2'd3) expData = ramM[idx]; else ramM[idx] = wdata;
                default: expData = 8'h00;
            endcase
        end
        checkOutput("bus_data_out", 32'(bus_data_out), 32'(expData));
        checkOutput("stall_idle", 32'(stall), 32'd0);
        checkOutput("cart_req_idle", 32'(cart_req), 32'd0);
    endtask

    initial begin
        logic [7:0]  oldByte;
        logic [23:0] a;
        logic [1:0]  st;
        int          r;
        int          dly;

        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_bus_data_out", 32'(bus_data_out), 32'h00);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_cart_req", 32'(cart_req), 32'd0);
        checkOutput("rst_cart_we", 32'(cart_we), 32'd0);
        checkOutput("rst_cart_addr", 32'(cart_addr), 32'd0);
        checkOutput("rst_cart_wdata", 32'(cart_wdata), 32'd0);

        for (int i = 0; i < 4096; i++) loadBios(12'(i), 8'($urandom));
        for (int i = 0; i < 4096; i++) applyStimulus(2'd2, 24'h001000 + 24'(i), 8'($urandom), 1'b1, 0, 8'h00);

        $display("[TB] directed checks");
        loadBios(12'h010, 8'h5A);
        applyStimulus(2'd3, 24'h000010, 8'h00, 1'b1, 0, 8'h00);
        checkOutput("bios_5a", 32'(bus_data_out), 32'h5A);

        applyStimulus(2'd2, 24'h001234, 8'hC3, 1'b1, 0, 8'h00);
        applyStimulus(2'd3, 24'h001234, 8'h00, 1'b1, 0, 8'h00);
        checkOutput("ram_c3", 32'(bus_data_out), 32'hC3);
        applyStimulus(2'd3, 24'h002010, 8'h00, 1'b1, 0, 8'h00);
        checkOutput("reg_zero", 32'(bus_data_out), 32'h00);

        applyStimulus(2'd3, 24'h123456, 8'h00, 1'b1, 5, 8'h99);
        checkOutput("cart_99", 32'(bus_data_out), 32'h99);

        applyStimulus(2'd3, 24'h300000, 8'h00, 1'b1, 0, 8'h00);
        checkOutput("cart_timeout_ff", 32'(bus_data_out), 32'hFF);

        applyStimulus(2'd3, 24'h001000, 8'h00, 1'b1, 0, 8'h00);
        oldByte = expData;
        applyStimulus(2'd1, 24'h001000, 8'h00, 1'b1, 0, 8'h00);
        checkOutput("irq_unchanged", 32'(bus_data_out), 32'(oldByte));
        applyStimulus(2'd3, 24'h001FFF, 8'h00, 1'b0, 0, 8'h00);

        cart_ack = 1'b1;
        cart_rdata = 8'h3C;
        tick();
        cart_ack = 1'b0;
        checkOutput("idle_ack_data", 32'(bus_data_out), 32'(expData));
        checkOutput("idle_ack_req", 32'(cart_req), 32'd0);

        oldByte = biosM[12'h020];
        bios_load_we = 1'b1;
        bios_load_addr = 12'h020;
        bios_load_data = ~oldByte;
        bus_status = 2'd3;
        bus_read = 1'b1;
        clk_ce = 1'b1;
        bus_address_in = 24'h000020;
        tick();
        bios_load_we = 1'b0;
        idleBus();
        checkOutput("bios_rw_same_clk", 32'(bus_data_out), 32'(oldByte));
        biosM[12'h020] = ~oldByte;
        expData = oldByte;
        applyStimulus(2'd3, 24'h000020, 8'h00, 1'b1, 0, 8'h00);

        bus_status = 2'd2;
        bus_write = 1'b1;
        clk_ce = 1'b1;
        bus_address_in = 24'h456789;
        bus_data_in = 8'hA5;
        tick();
        idleBus();
        checkOutput("cw_req", 32'(cart_req), 32'd1);
        checkOutput("cw_we", 32'(cart_we), 32'd1);
        checkOutput("cw_wdata", 32'(cart_wdata), 32'hA5);
        checkOutput("cw_addr", 32'(cart_addr), 32'h056789);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expData = 8'h00;
        checkOutput("abort_req", 32'(cart_req), 32'd0);
        checkOutput("abort_stall", 32'(stall), 32'd0);
        checkOutput("abort_data", 32'(bus_data_out), 32'h00);
        cart_ack = 1'b1;
        cart_rdata = 8'h77;
        tick();
        cart_ack = 1'b0;
        tick();
        checkOutput("late_ack_req", 32'(cart_req), 32'd0);
        checkOutput("late_ack_stall", 32'(stall), 32'd0);
        checkOutput("late_ack_data", 32'(bus_data_out), 32'h00);
        applyStimulus(2'd3, 24'h001234, 8'h00, 1'b1, 0, 8'h00);
        checkOutput("ram_kept_after_reset", 32'(bus_data_out), 32'hC3);

        $display("[TB] random traffic");
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: a = 24'($urandom_range(0, 24'h000FFF));
                1: a = 24'($urandom_range(24'h001000, 24'h001FFF));
                2: a = 24'($urandom_range(24'h002000, 24'h0020FF));
                default: a = 24'($urandom_range(24'h002100, 24'hFFFFFF));
            endcase
            st = 2'($urandom_range(0, 3));
            dly = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
            applyStimulus(st, a, 8'($urandom), ($urandom_range(0, 4) != 0), dly, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/minx_mem_responder.md
MINX_MEM_RESPONDER -- requirements
Module: minx_mem_responder

Interface
REQ-001 Parameter CART_TIMEOUT, default 255: cycles to wait for cart_ack before abandoning a cartridge access.
REQ-002 clk  in  1  system clock; all state SHALL update on posedge clk only.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 clk_ce  in  1  CPU bus clock enable; bus signals SHALL be sampled only when clk_ce=1.
REQ-005 bus_address_in  in  24  address driven by the minx bus initiator.
REQ-006 bus_data_in  in  8  write data from the initiator.
REQ-007 bus_status  in  2  bus command: 0 idle, 1 IRQ read, 2 memory write, 3 memory read.
REQ-008 bus_read / bus_write  in  1 each  read / write strobe.
REQ-009 bus_data_out  out  8  read data returned to the initiator (the minx data_in).
REQ-010 stall  out  1  high while a response is pending; upstream gates clk_ce with it.
REQ-011 bios_load_we / bios_load_addr / bios_load_data  in  1/12/8  BIOS ROM preload port, usable at any time.
REQ-012 cart_req  out  1  cartridge access request; cart_we out 1; cart_addr out 21; cart_wdata out 8.
REQ-013 cart_ack  in  1  one-cycle completion pulse; cart_rdata in 8 valid in the cart_ack cycle.

Function
REQ-014 Decode on bus_address_in: 0x000000-0x000FFF BIOS ROM (4 KB); 0x001000-0x001FFF RAM (4 KB); 0x002000-0x0020FF register space; 0x002100-0xFFFFFF cartridge.
REQ-015 An access SHALL start only in a cycle with clk_ce=1, bus_status=3 with bus_read=1 (read), or bus_status=2 with bus_write=1 (write); IRQ reads and idle cycles SHALL be ignored.
REQ-016 BIOS read: bus_data_out SHALL hold ROM[addr[11:0]] from the next clk onward; stall stays 0; BIOS writes from the bus SHALL be ignored.
REQ-017 RAM read: bus_data_out SHALL hold RAM[addr[11:0]] from the next clk; RAM write: stored on the start clk; stall stays 0.
REQ-018 Register-space access: bus_data_out SHALL be 8'h00 from the next clk; no storage, no stall.
REQ-019 Cartridge access: on the start clk the FSM moves IDLE->CART_WAIT, asserts cart_req and stall, latches cart_addr=addr[20:0], cart_we, cart_wdata=bus_data_in.
REQ-020 cart_req, cart_addr, cart_we, cart_wdata SHALL remain stable in CART_WAIT until cart_ack.
REQ-021 On cart_ack in CART_WAIT: the FSM moves to IDLE and deasserts cart_req; stall deasserts the next clk; for reads bus_data_out <= cart_rdata.
REQ-022 Timeout counter (8 bit) SHALL clear on entry to CART_WAIT and increment each CART_WAIT clk; on reaching CART_TIMEOUT without ack: IDLE, cart_req=0, stall=0, read data 8'hFF.
REQ-023 cart_ack while IDLE SHALL be ignored.
REQ-024 bus_data_out SHALL hold its last value between accesses.
REQ-025 No new access SHALL be accepted while in CART_WAIT, regardless of clk_ce.
REQ-026 A bios_load_we write and a bus BIOS read in the same clk: the read SHALL return the pre-write byte.
REQ-027 Address arithmetic SHALL use only the low 12 bits (internal) or 21 bits (cartridge); upper bits select the region only.

Reset
REQ-028 On reset: FSM=IDLE, stall=0, cart_req=0, cart_we=0, cart_addr=0, cart_wdata=0, bus_data_out=8'h00, timeout counter=0.
REQ-029 Reset during CART_WAIT SHALL abort the access in the same clk; a later cart_ack SHALL be ignored.
REQ-030 RAM and BIOS ROM contents SHALL NOT be cleared by reset.

Verification
REQ-031 Preload BIOS[0x010]=0x5A, read 0x000010 -> bus_data_out=0x5A next clk, stall never high.
REQ-032 Write 0xC3 to 0x001234, read 0x001234 -> 0xC3; read 0x002010 -> 0x00.
REQ-033 Read 0x123456, cart_ack with cart_rdata=0x99 after 5 clks -> cart_addr=0x123456, cart_req/stall high 5 clks, bus_data_out=0x99.
REQ-034 Read 0x300000 with no ack -> cart_req drops after CART_TIMEOUT clks, bus_data_out=0xFF, stall=0.
REQ-035 Reset asserted 2 clks into a cartridge write -> cart_req=0, stall=0 next clk; ack pulse afterwards changes nothing.
REQ-036 IRQ read (bus_status=1) to 0x001000 -> no state change, bus_data_out unchanged.
